// File: rtl/x86_pkg.sv
// ----------------------------------------------------------------------------
// x86_pkg
// Shared definitions for the x86 front end (prefetch queue and decoder).
//   state_e   : prefetch FSM state encoding (S_FETCH, S_FULL, S_YIELD)
//   RESET_CS_DEF / RESET_IP_DEF : code segment / IP after reset
//   PHYS()    : real-mode physical address, ({cs,4'h0} + ip) mod 2^20
// ----------------------------------------------------------------------------
package x86_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_YIELD = 2'd2
    } state_e;

    localparam logic [15:0] RESET_CS_DEF = 16'hF000;
    localparam logic [15:0] RESET_IP_DEF = 16'hFFF0;

    // The 20-bit sum drops the carry out of bit 19, giving the 8086 wrap.
    function automatic logic [19:0] PHYS(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'h0} + {4'h0, ip};
    endfunction

endpackage

// File: rtl/x86prefetch_if.sv
// ----------------------------------------------------------------------------
// x86prefetch_if
// Bundles the memory-side fetch handshake and the decoder-side queue port
// of the prefetch block.
//   Memory side : mem_address, mem_rd, mem_ready, mem_data, bus_busy
//   Control     : flush, flush_cs, flush_ip
//   Decoder side: q_data, q_ip, q_valid, q_take, q_count
// Modports:
//   master : the prefetch queue itself
//   slave  : everything around it (memory, execution unit, decoder)
// ----------------------------------------------------------------------------
interface x86prefetch_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [19:0]   mem_address;
    logic          mem_rd;
    logic          mem_ready;
    logic [7:0]    mem_data;
    logic          bus_busy;
    logic          flush;
    logic [15:0]   flush_cs;
    logic [15:0]   flush_ip;
    logic [7:0]    q_data;
    logic [15:0]   q_ip;
    logic          q_valid;
    logic          q_take;
    logic [CW-1:0] q_count;

    modport master (
        output mem_address, mem_rd, q_data, q_ip, q_valid, q_count,
        input  mem_ready, mem_data, bus_busy, flush, flush_cs, flush_ip, q_take
    );

    modport slave (
        input  mem_address, mem_rd, q_data, q_ip, q_valid, q_count,
        output mem_ready, mem_data, bus_busy, flush, flush_cs, flush_ip, q_take
    );

endinterface

// File: rtl/x86prefetch_fifo.sv
// ----------------------------------------------------------------------------
// x86prefetch_fifo
// Byte storage for the prefetch queue: circular buffer with head/tail
// pointers that wrap naturally (DEPTH is a power of two) and a byte count.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : synchronous flush of pointers and count (wins over push/pop)
//   push, wdata  : write a byte at the tail
//   pop          : advance the head (caller guarantees count != 0)
//   rdata        : head byte, forced to 0 while empty
//   count        : bytes held, 0..DEPTH
// ----------------------------------------------------------------------------
module x86prefetch_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never visible because the
    // head byte is masked whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (push && !clear) mem_q[tail_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[head_q] : 8'h00;
    assign count = count_q;

endmodule

// File: rtl/x86prefetch.sv
// ----------------------------------------------------------------------------
// x86prefetch
// Real-mode instruction prefetch queue. Fetches code bytes at CS:IP into a
// DEPTH-byte FIFO and hands them, with their IP, to the decoder one at a
// time. Yields the bus while bus_busy is high; flush restarts at a new CS:IP.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : x86prefetch_if.master (memory fetch port, flush control,
//                  decoder queue port)
//   stall_count  : only with X86PREFETCH_STALL_CNT_EN defined; cycles with
//                  an empty queue outside S_YIELD, saturating, reset-only clear
// ----------------------------------------------------------------------------
module x86prefetch
    import x86_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_CS = RESET_CS_DEF,
    parameter logic [15:0] RESET_IP = RESET_IP_DEF,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    x86prefetch_if.master bus
`ifdef X86PREFETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    state_e        state_q, state_d;
    logic [15:0]   fetch_cs_q, fetch_cs_d;
    logic [15:0]   fetch_ip_q, fetch_ip_d;
    logic [15:0]   q_ip_q, q_ip_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          q_valid;
    logic          mem_rd;
    logic          push;
    logic          pop;

    // Reset is included so no request escapes while the block is held.
    assign mem_rd  = (state_q == S_FETCH) && !bus.bus_busy && !bus.flush && !reset;
    assign push    = mem_rd && bus.mem_ready;
    assign q_valid = (count != '0);
    assign pop     = bus.q_take && q_valid && !bus.flush;

    assign count_next = count + CW'(push) - CW'(pop);

    x86prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (bus.flush),
        .push  (push),
        .pop   (pop),
        .wdata (bus.mem_data),
        .rdata (bus.q_data),
        .count (count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_cs_d = fetch_cs_q;
        fetch_ip_d = fetch_ip_q;
        q_ip_d     = q_ip_q;
        if (bus.flush) begin
            state_d    = bus.bus_busy ? S_YIELD : S_FETCH;
            fetch_cs_d = bus.flush_cs;
            fetch_ip_d = bus.flush_ip;
            q_ip_d     = bus.flush_ip;
        end else begin
            if (bus.bus_busy)
                state_d = S_YIELD;
            else if (count_next == CW'(DEPTH))
                state_d = S_FULL;
            else
                state_d = S_FETCH;
            // IP wraps within the segment; CS is never touched by fetching.
            if (push) fetch_ip_d = fetch_ip_q + 16'd1;
            if (pop)  q_ip_d     = q_ip_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            q_ip_q     <= RESET_IP;
        end else begin
            state_q    <= state_d;
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            q_ip_q     <= q_ip_d;
        end
    end

    assign bus.mem_address = PHYS(fetch_cs_q, fetch_ip_q);
    assign bus.mem_rd      = mem_rd;
    assign bus.q_ip        = q_ip_q;
    assign bus.q_valid     = q_valid;
    assign bus.q_count     = count;

`ifdef X86PREFETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_q <= 16'h0000;
        else if (!q_valid && (state_q != S_YIELD) && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_x86prefetch.sv
module tb_x86prefetch;
    import x86_pkg::*;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    x86prefetch_if #(.DEPTH(8)) bus ();

`ifdef X86PREFETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    x86prefetch #(.DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus)
`ifdef X86PREFETCH_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    // Memory returns a byte derived from its address so loss/duplication shows.
    function automatic logic [7:0] data_at(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign bus.mem_data = data_at(bus.mem_address);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.bus_busy  = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_cs  = 16'h0000;
        bus.flush_ip  = 16'h0000;
        bus.q_take    = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        check("rst_mem_rd",  32'(bus.mem_rd), 32'h0);
        check("rst_q_valid", 32'(bus.q_valid), 32'h0);
        check("rst_q_count", 32'(bus.q_count), 32'h0);
        check("rst_q_data",  32'(bus.q_data), 32'h0);
        check("rst_q_ip",    32'(bus.q_ip), 32'hFFF0);
        check("rst_addr",    32'(bus.mem_address), 32'hFFFF0);
        check("rst_state",   32'(dut.state_q), 32'(S_FETCH));

        // Reset release: 8 sequential fetches then full
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_addr%0d", i), 32'(bus.mem_address), 32'h000FFFF0 + 32'(i));
            check($sformatf("fill_rd%0d", i), 32'(bus.mem_rd), 32'h1);
            tick();
        end
        check("full_count", 32'(bus.q_count), 32'd8);
        check("full_rd",    32'(bus.mem_rd), 32'h0);
        check("full_state", 32'(dut.state_q), 32'(S_FULL));
        check("full_q_ip",  32'(bus.q_ip), 32'hFFF0);
        check("full_valid", 32'(bus.q_valid), 32'h1);
        check("full_data",  32'(bus.q_data), 32'(data_at(20'hFFFF0)));

        // Pop one byte while full: fetch resumes next cycle
        bus.q_take = 1'b1;
        #1;
        check("fullpop_rd", 32'(bus.mem_rd), 32'h0);
        tick();
        bus.q_take = 1'b0;
        #1;
        check("fullpop_count7", 32'(bus.q_count), 32'd7);
        check("fullpop_rd1",    32'(bus.mem_rd), 32'h1);
        check("fullpop_addr",   32'(bus.mem_address), 32'hFFFF8);
        check("fullpop_q_ip",   32'(bus.q_ip), 32'hFFF1);
        check("fullpop_data",   32'(bus.q_data), 32'(data_at(20'hFFFF1)));
        tick();
        check("refill_count8",  32'(bus.q_count), 32'd8);
        check("refill_rd0",     32'(bus.mem_rd), 32'h0);

        // Flush to 0000:FFFE, IP wraps within CS=0
        bus.flush    = 1'b1;
        bus.flush_cs = 16'h0000;
        bus.flush_ip = 16'hFFFE;
        #1;
        check("flush_rd0", 32'(bus.mem_rd), 32'h0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("fl_count",  32'(bus.q_count), 32'd0);
        check("fl_valid",  32'(bus.q_valid), 32'h0);
        check("fl_addr",   32'(bus.mem_address), 32'h0FFFE);
        check("fl_rd",     32'(bus.mem_rd), 32'h1);
        check("fl_q_ip",   32'(bus.q_ip), 32'hFFFE);
        tick();
        check("fl_valid1", 32'(bus.q_valid), 32'h1);
        check("fl_data0",  32'(bus.q_data), 32'(data_at(20'h0FFFE)));
        check("fl_addr1",  32'(bus.mem_address), 32'h0FFFF);
        bus.q_take = 1'b1;
        #1;
        check("pop_ip0",   32'(bus.q_ip), 32'hFFFE);
        tick();
        check("pop_ip1",   32'(bus.q_ip), 32'hFFFF);
        check("pop_data1", 32'(bus.q_data), 32'(data_at(20'h0FFFF)));
        check("wrap_addr", 32'(bus.mem_address), 32'h00000);
        check("pop_cnt1",  32'(bus.q_count), 32'd1);
        tick();
        check("pop_ip2",   32'(bus.q_ip), 32'h0000);
        check("pop_data2", 32'(bus.q_data), 32'(data_at(20'h00000)));
        check("pop_addr2", 32'(bus.mem_address), 32'h00001);
        bus.q_take = 1'b0;
        tick();
        tick();
        check("three_count", 32'(bus.q_count), 32'd3);

        // Flush + mem_ready + q_take together with 3 bytes queued
        bus.flush    = 1'b1;
        bus.flush_cs = 16'h1234;
        bus.flush_ip = 16'h0100;
        bus.q_take   = 1'b1;
        #1;
        check("fl3_rd0", 32'(bus.mem_rd), 32'h0);
        tick();
        bus.flush  = 1'b0;
        bus.q_take = 1'b0;
        #1;
        check("fl3_count", 32'(bus.q_count), 32'd0);
        check("fl3_valid", 32'(bus.q_valid), 32'h0);
        check("fl3_q_ip",  32'(bus.q_ip), 32'h0100);
        check("fl3_addr",  32'(bus.mem_address), 32'h12440);
        check("fl3_rd1",   32'(bus.mem_rd), 32'h1);
        check("fl3_data",  32'(bus.q_data), 32'h0);
        tick();
        check("fl3_valid1", 32'(bus.q_valid), 32'h1);
        check("fl3_data1",  32'(bus.q_data), 32'(data_at(20'h12440)));
        check("fl3_addr1",  32'(bus.mem_address), 32'h12441);
        check("fl3_cnt1",   32'(bus.q_count), 32'd1);

        // bus_busy for 4 cycles mid-fetch
        bus.bus_busy = 1'b1;
        #1;
        check("busy_rd_comb", 32'(bus.mem_rd), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("busy_state%0d", i), 32'(dut.state_q), 32'(S_YIELD));
            check($sformatf("busy_rd%0d", i), 32'(bus.mem_rd), 32'h0);
            check($sformatf("busy_cnt%0d", i), 32'(bus.q_count), 32'd1);
            check($sformatf("busy_addr%0d", i), 32'(bus.mem_address), 32'h12441);
        end
        bus.bus_busy = 1'b0;
        #1;
        check("unbusy_rd0", 32'(bus.mem_rd), 32'h0);
        tick();
        check("resume_state", 32'(dut.state_q), 32'(S_FETCH));
        check("resume_rd",    32'(bus.mem_rd), 32'h1);
        check("resume_addr",  32'(bus.mem_address), 32'h12441);
        tick();
        check("resume_cnt2",  32'(bus.q_count), 32'd2);
        check("resume_addr2", 32'(bus.mem_address), 32'h12442);
        bus.mem_ready = 1'b0;
        bus.q_take    = 1'b1;
        #1;
        check("drain_d0",  32'(bus.q_data), 32'(data_at(20'h12440)));
        check("drain_ip0", 32'(bus.q_ip), 32'h0100);
        tick();
        check("drain_d1",  32'(bus.q_data), 32'(data_at(20'h12441)));
        check("drain_ip1", 32'(bus.q_ip), 32'h0101);
        check("drain_c1",  32'(bus.q_count), 32'd1);
        tick();
        check("drain_c0",  32'(bus.q_count), 32'd0);
        check("drain_v0",  32'(bus.q_valid), 32'h0);
        check("drain_ip2", 32'(bus.q_ip), 32'h0102);
        tick();
        check("empty_take_cnt", 32'(bus.q_count), 32'd0);
        check("empty_take_ip",  32'(bus.q_ip), 32'h0102);
        bus.q_take = 1'b0;

        // Asynchronous reset mid-cycle
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("pre_rst_cnt", 32'(bus.q_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cnt",  32'(bus.q_count), 32'd0);
        check("arst_rd",   32'(bus.mem_rd), 32'h0);
        check("arst_addr", 32'(bus.mem_address), 32'hFFFF0);
        check("arst_q_ip", 32'(bus.q_ip), 32'hFFF0);

        bus.mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rel_rd",   32'(bus.mem_rd), 32'h1);
        check("rel_addr", 32'(bus.mem_address), 32'hFFFF0);

`ifdef X86PREFETCH_STALL_CNT_EN
        repeat (10) tick();
        check("stall10", 32'(stall_count), 32'd10);
        bus.flush    = 1'b1;
        bus.flush_cs = 16'h0000;
        bus.flush_ip = 16'h0000;
        tick();
        bus.flush = 1'b0;
        check("stall_flush", 32'(stall_count), 32'd11);
        repeat (65530) @(posedge clock);
        #1;
        check("stall_sat", 32'(stall_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
